// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// IFETCH_PC_TAG_EN adds the fetch address to every buffered entry.
package ifetch_pkg;

    localparam int          IFETCH_WORD_W        = 32;
    localparam logic [31:0] IFETCH_PC_STEP       = 32'd4;
    localparam int          IFETCH_DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_BUSY,
        FETCH_DISCARD
    } fetch_state_e;

`ifdef IFETCH_PC_TAG_EN
    typedef struct packed {
        logic [31:0]              pc;
        logic [IFETCH_WORD_W-1:0] word;
    } ifetch_entry_t;
`else
    typedef struct packed {
        logic [IFETCH_WORD_W-1:0] word;
    } ifetch_entry_t;
`endif

    localparam int IFETCH_ENTRY_W = $bits(ifetch_entry_t);

    function automatic logic [31:0] ifetch_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Instruction memory read bus: one outstanding req/ack transaction at a time.
interface ifetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/ifetch_fifo.sv
// Synchronous prefetch FIFO with a registered head word; flush dominates push/pop.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = IFETCH_DEFAULT_DEPTH,
    parameter int WIDTH = IFETCH_ENTRY_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [WIDTH-1:0] head_reg;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             do_push, do_pop;
    logic             head_load, head_bypass;

    assign full  = (count_reg == FULL_CNT);
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign head  = head_reg;

    always_comb begin
        do_pop      = pop && !empty;
        do_push     = push && (!full || do_pop);
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        head_load   = 1'b0;
        head_bypass = 1'b0;
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            if (do_push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            if (do_push && !do_pop)      count_next = count_reg + CNT_W'(1);
            else if (!do_push && do_pop) count_next = count_reg - CNT_W'(1);
            // The new head comes from the array unless the pushed word becomes head directly.
            if (do_pop) begin
                head_load   = (count_next != '0);
                head_bypass = (count_reg == CNT_W'(1));
            end else if (empty && do_push) begin
                head_load   = 1'b1;
                head_bypass = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            if (head_load) begin
                head_reg <= head_bypass ? push_data : mem_reg[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: sequential prefetch into a FIFO with PC redirect/flush.
// Define IFETCH_PC_TAG_EN to tag entries with their address and expose I_pc.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int          DEPTH    = IFETCH_DEFAULT_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    ifetch_if.master    mem,
    output logic [31:0] I,
    output logic        W_IR_valid,
    input  logic        write_ir,
    input  logic        pc_load,
    input  logic [31:0] pc_new
`ifdef IFETCH_PC_TAG_EN
    ,
    output logic [31:0] I_pc
`endif
);

    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_state_e  state_reg, state_next;
    logic          mem_req_reg, mem_req_next;
    logic [31:0]   mem_addr_reg, mem_addr_next;
    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic          acked, remain, launch;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count, count_nx;
    ifetch_entry_t push_entry, head_entry;
    logic [IFETCH_ENTRY_W-1:0] head_data;

    assign mem.mem_req  = mem_req_reg;
    assign mem.mem_addr = mem_addr_reg;
    assign head_entry   = head_data;
    assign I            = head_entry.word;
    assign W_IR_valid   = !fifo_empty;
`ifdef IFETCH_PC_TAG_EN
    assign I_pc         = head_entry.pc;
`endif

    always_comb begin
        push_entry      = '0;
        push_entry.word = mem.mem_rdata;
`ifdef IFETCH_PC_TAG_EN
        push_entry.pc   = mem_addr_reg;
`endif
    end

    always_comb begin
        acked     = mem_req_reg && mem.mem_ack;
        fifo_pop  = write_ir && !fifo_empty;
        // A response for a discarded or concurrently redirected request is dropped.
        fifo_push = acked && (state_reg == FETCH_BUSY) && !pc_load && (!fifo_full || fifo_pop);

        count_nx = fifo_count;
        if (pc_load)                    count_nx = '0;
        else if (fifo_push && !fifo_pop) count_nx = fifo_count + CNT_W'(1);
        else if (!fifo_push && fifo_pop) count_nx = fifo_count - CNT_W'(1);

        fetch_pc_next = fetch_pc_reg;
        if (pc_load)        fetch_pc_next = ifetch_align(pc_new);
        else if (fifo_push) fetch_pc_next = fetch_pc_reg + IFETCH_PC_STEP;

        remain = mem_req_reg && !acked;
        launch = !remain && (count_nx < FULL_CNT);

        state_next = state_reg;
        case (state_reg)
            FETCH_IDLE: begin
                if (launch) state_next = FETCH_BUSY;
            end
            FETCH_BUSY: begin
                if (acked)        state_next = launch ? FETCH_BUSY : FETCH_IDLE;
                else if (pc_load) state_next = FETCH_DISCARD;
            end
            FETCH_DISCARD: begin
                if (acked) state_next = launch ? FETCH_BUSY : FETCH_IDLE;
            end
            default: state_next = FETCH_IDLE;
        endcase

        mem_req_next  = remain || launch;
        mem_addr_next = launch ? fetch_pc_next : mem_addr_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= FETCH_IDLE;
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= RESET_PC;
            fetch_pc_reg <= RESET_PC;
        end else begin
            state_reg    <= state_next;
            mem_req_reg  <= mem_req_next;
            mem_addr_reg <= mem_addr_next;
            fetch_pc_reg <= fetch_pc_next;
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (IFETCH_ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (pc_load),
        .head      (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch unit that supplies the multi-cycle controller with instruction words. It reads sequential words from instruction memory over a req/ack handshake and buffers them in a small prefetch FIFO. It presents the head word as `I` with `W_IR_valid`, and retires it when the controller pulses `write_ir`. A PC redirect flushes the buffer and restarts fetch at the new address; a redirect comes from a taken branch, i.e. `write_pc` together with a new PC value.

## Interface
Parameters:
- `DEPTH`, 4: prefetch FIFO entries; power of two, 2..16.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `mem_req`  out  1  read request to instruction memory; registered.
- `mem_addr`  out  32  word-aligned read address; registered; stable while `mem_req`=1.
- `mem_ack`  in  1  read complete; `mem_rdata` valid this cycle; only meaningful when `mem_req`=1.
- `mem_rdata`  in  32  instruction word.
- `I`  out  32  head-of-FIFO instruction word to the controller.
- `W_IR_valid`  out  1  `I` is valid.
- `write_ir`  in  1  controller latches `I`; pops head when `W_IR_valid`=1.
- `pc_load`  in  1  redirect strobe, driven by the datapath on a taken branch.
- `pc_new`  in  32  redirect target; bits [1:0] ignored, treated as 0.
- `I_pc`  out  32  address of the head word; present only with `IFETCH_PC_TAG_EN`.

## Operation
- Registers:
  - `fetch_pc`: next address to request.
  - FIFO: `DEPTH` entries, `count` 0..`DEPTH`.
  - `inflight`: a request is outstanding.
  - `discard`: the outstanding response must be dropped.
- Memory protocol:
  - Once `mem_req` rises, `mem_req` and `mem_addr` hold until the cycle `mem_ack`=1.
  - One request is outstanding at a time.
  - `mem_addr` <= `fetch_pc` when a request is launched.
- Launch condition, evaluated each cycle using the post-update `count_nx` (after this cycle's push and pop):
  - Launch if no request will remain outstanding after this cycle and `count_nx` < `DEPTH`.
  - Back-to-back: on an ack cycle, `mem_req` stays 1 with the next address if the condition holds.
- Ack with `discard`=0: push `mem_rdata` (tagged with `mem_addr` when the macro is on); `fetch_pc` += 4.
- Ack with `discard`=1: drop the data; clear `discard`; `fetch_pc` is unchanged (already holds the redirect target).
- Pop: `write_ir`=1 and `W_IR_valid`=1 remove the head. `write_ir` on an empty FIFO is ignored.
- Redirect (`pc_load`=1):
  - Flush: `count` <= 0.
  - `fetch_pc` <= {`pc_new`[31:2], 2'b00}.
  - If a request is in flight and not acked this cycle, set `discard`.
  - If its ack arrives in the same cycle, drop that data.
- Simultaneous events:
  - `pc_load` dominates push and pop in the same cycle.
  - Push and pop together leave `count` unchanged.
- `fetch_pc` wraps modulo 2^32.
- Reset values: `mem_req`=0, `mem_addr`=`RESET_PC`, `W_IR_valid`=0, `I`=0, `I_pc`=0, `count`=0, `inflight`=0, `discard`=0, `fetch_pc`=`RESET_PC`.
- `rst` during an outstanding request drops the request unconditionally; memory must tolerate an abandoned request across reset.

## Timing
- First `mem_req`=1 in the first cycle after `rst` deasserts.
- Ack in cycle N -> `W_IR_valid`=1, `I`=word in cycle N+1.
- Ack in cycle N with space remaining -> next `mem_req`/`mem_addr` valid in N+1, so zero-wait memory sustains one word per cycle.
- Pop in cycle N -> next entry on `I` in N+1.
- Pop in cycle N from a full FIFO -> request launched in N+1.
- Redirect in cycle N:
  - `W_IR_valid`=0 in N+1.
  - With nothing in flight, `mem_req`=1 with `mem_addr`=target in N+1.
  - Otherwise the target is launched the cycle after the discarded ack.
- `I` is undefined-but-stable when `W_IR_valid`=0; it holds its last value.

## Configuration
- `IFETCH_PC_TAG_EN` defined:
  - FIFO entries are 64 bits (word plus address).
  - Port `I_pc` exists and equals the address of the word on `I`.
- `IFETCH_PC_TAG_EN` undefined:
  - Entries are 32 bits.
  - No `I_pc` port.
  - All other behaviour is identical.

## Structure
- Shared package `ifetch_pkg`:
  - `IFETCH_WORD_W`=32.
  - `IFETCH_PC_STEP`=4.
  - Default `DEPTH`.
  - Entry struct typedef (word, optional pc).
- One sub-module, `ifetch_fifo`:
  - Synchronous FIFO with `DEPTH`/width parameters.
  - Ports: push, pop, flush, full/empty/count.
  - Registered head output.
- The top level holds `fetch_pc`, the request/discard logic and the redirect handling.

## Test plan
- Reset release, zero-wait memory (`mem_ack` in the same cycle as `mem_req`), `write_ir` tied 0:
  - Addresses 0,4,8,12 are requested, then `mem_req`=0 with `count`=4.
  - `I`=word@0.
- Full FIFO, pulse `write_ir` once: `I`=word@4 next cycle; one new request to address 16 the cycle after the pop.
- Redirect mid-request:
  - Request to 8 outstanding with ack delayed 3 cycles; `pc_load`=1, `pc_new`=32'h100.
  - The ack@8 data never appears on `I`.
  - Next `mem_addr`=32'h100 the cycle after that ack; first valid `I`=word@0x100.
- Same cycle `pc_load`=1 (`pc_new`=0x40), `write_ir`=1 and `mem_ack`=1:
  - FIFO is empty next cycle; the acked word is dropped.
  - Next request is to 0x40.
- `pc_new`=32'hFFFF_FFFE: `mem_addr`=32'hFFFF_FFFC, then wraps to 0.
- With `IFETCH_PC_TAG_EN`, random stall/pop stream: `I_pc` matches the address of every `I` delivered, in order, with no drops or duplicates.
